network_sim_sequencer: RTL and testbench
========================================

Name: network_sim_sequencer

Overview:
Drives the synchronous Boolean network update block (`network_logic`) from the other side of its state interface. The block:
- holds the authoritative network state;
- presents it as `current_state` together with `iteration_number`;
- captures the registered `next_state` one clock later;
- repeats for a requested number of iterations.

Each state, including the initial one, streams out on a valid/ready trace port. Fixed-point detection can optionally end the run early. It sits between the host/testbench loader and `network_logic`.

Parameters:
- STATE_W, 61, width of the network state vector; equals `` `STATE ``.
- ITER_W, 10, width of the iteration counter; equals the width of `network_logic` `iteration_number`.

Ports:
- clk  in  1  single clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle run request; sampled only in IDLE.
- init_state  in  STATE_W  initial state; captured on accepted start.
- num_iter  in  ITER_W  number of update steps; captured on accepted start.
- stop_on_fixed  in  1  end early on fixed point; captured on accepted start.
- net_current_state  out  STATE_W  drives `network_logic` `current_state`.
- net_iteration_number  out  ITER_W  drives `network_logic` `iteration_number`.
- net_next_state  in  STATE_W  from `network_logic` `next_state`; valid 1 clk after presentation.
- trace_valid  out  1  trace word available.
- trace_ready  in  1  consumer accepts the trace word.
- trace_data  out  STATE_W  state being reported.
- trace_iter  out  ITER_W  iteration index of trace_data; 0 = initial state.
- busy  out  1  high in any state except IDLE.
- done  out  1  one-cycle pulse at run end.
- fixed_point  out  1  sticky; the last captured state equalled its predecessor.
- iter_count  out  ITER_W  number of completed update steps.

Behaviour:
- Reset (asynchronous, active-high):
  - FSM goes to IDLE.
  - state_reg, iteration counter, num_iter_q, stop_q, fixed_point and done are all 0.
  - trace_valid = 0 and busy = 0.
  - A reset mid-run aborts immediately with no done pulse. A trace word that was offered but not accepted is dropped.
- Continuous outputs:
  - net_current_state = state_reg.
  - net_iteration_number = iter counter.
  - trace_data = state_reg.
  - trace_iter = iter counter.
  - iter_count = iter counter.
- FSM states: IDLE, EMIT, PRESENT, CAPTURE, FINISH.
- IDLE:
  - On start=1: state_reg <= init_state, iter <= 0, num_iter_q <= num_iter, stop_q <= stop_on_fixed, fixed_point <= 0; go to EMIT.
  - start in any other state is ignored.
- EMIT:
  - trace_valid = 1.
  - Hold all state until trace_valid & trace_ready. trace_data and trace_iter stay stable while stalled.
  - On handshake: if iter == num_iter_q, or stop_q & fixed_point, go to FINISH; otherwise go to PRESENT.
- PRESENT:
  - One cycle; `network_logic` registers f(state_reg) at the closing edge.
  - Go to CAPTURE.
- CAPTURE:
  - fixed_point <= (net_next_state == state_reg).
  - state_reg <= net_next_state.
  - iter <= iter + 1.
  - Go to EMIT.
- FINISH:
  - done = 1 for exactly one cycle; go to IDLE.
  - state_reg, iter and fixed_point hold their values until the next start.
- Latency:
  - Each update step costs 3 cycles minimum (PRESENT, CAPTURE, EMIT) when trace_ready is held high.
  - A full run takes 1 + 3·num_iter + 1 cycles from start to done.
- Boundary conditions:
  - num_iter = 0: emit the initial state (iter 0) only, then done; `network_logic` is never sampled.
  - Counter range: iter never exceeds num_iter_q ≤ 2^ITER_W − 1, so it cannot wrap.
  - Fixed point with stop_q = 0: the run continues to num_iter_q and fixed_point remains asserted/updated per step.
  - trace_ready held low indefinitely: the FSM stalls in EMIT with no state change.
  - net_next_state is ignored outside CAPTURE.

Decomposition:
- Package network_sim_pkg holds:
  - the sequencer state enum (`seq_state_e`: IDLE, EMIT, PRESENT, CAPTURE, FINISH);
  - localparams for the default STATE_W and ITER_W, tied to `` `STATE `` and the 10-bit iteration width.
- Single module, no sub-module.
- The testbench instantiates network_sim_sequencer together with `network_logic`, or with a stub network.

Test Plan:
1. Identity stub (next = current), init 61'h5, num_iter 4, stop_on_fixed 0, ready=1 -> trace iter 0..4 all data 61'h5; fixed_point=1; done at cycle 14; iter_count=4.
2. Same stub, stop_on_fixed 1, num_iter 10 -> trace iter 0,1 only; done after iter 1; fixed_point=1; iter_count=1.
3. Increment stub (next = current + 1), init 0, num_iter 3, trace_ready low for 5 cycles on iter 2 -> data 0,1,2,3 in order; iter 2 word held stable throughout the stall; no duplicate or lost word.
4. num_iter 0, init 61'hABC -> single trace word (iter 0, 61'hABC); done; net_iteration_number stays 0.
5. rst asserted during PRESENT of iter 2 -> busy, trace_valid and fixed_point go 0 immediately; no done; a new start then runs cleanly from iter 0.
6. Real `network_logic` with `` `TOGGLE ``=2, TCR_HIGH set in init -> net_iteration_number ticks 0,1,2,…; trace matches the golden software model per step.

Source files
------------

// File: rtl/network_sim_pkg.sv
// Shared types and default widths for the Boolean network sequencer.
// The state width matches the network_logic state vector; the iteration width matches its counter.
package network_sim_pkg;

   localparam int unsigned NET_STATE_W = 61;
   localparam int unsigned NET_ITER_W  = 10;

   typedef enum logic [2:0] {
      IDLE,
      EMIT,
      PRESENT,
      CAPTURE,
      FINISH
   } seq_state_e;

endpackage

// File: rtl/network_sim_sequencer.sv
// Steps a registered Boolean network update block, streaming every visited state on a trace port
// and optionally ending the run once the network settles on a fixed point.
module network_sim_sequencer
   import network_sim_pkg::*;
#(
   parameter int unsigned STATE_W = NET_STATE_W,
   parameter int unsigned ITER_W  = NET_ITER_W
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   input  logic [STATE_W-1:0] init_state,
   input  logic [ITER_W-1:0]  num_iter,
   input  logic               stop_on_fixed,
   output logic [STATE_W-1:0] net_current_state,
   output logic [ITER_W-1:0]  net_iteration_number,
   input  logic [STATE_W-1:0] net_next_state,
   output logic               trace_valid,
   input  logic               trace_ready,
   output logic [STATE_W-1:0] trace_data,
   output logic [ITER_W-1:0]  trace_iter,
   output logic               busy,
   output logic               done,
   output logic               fixed_point,
   output logic [ITER_W-1:0]  iter_count
);

   seq_state_e         state_q, state_d;
   logic [STATE_W-1:0] state_reg;
   logic [ITER_W-1:0]  iter_q;
   logic [ITER_W-1:0]  num_iter_q;
   logic               stop_q;
   logic               fixed_q;
   logic               emit_fire;
   logic               run_over;

   assign emit_fire = trace_valid & trace_ready;
   assign run_over  = (iter_q == num_iter_q) | (stop_q & fixed_q);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (start) state_d = EMIT;
         EMIT:    if (emit_fire) state_d = run_over ? FINISH : PRESENT;
         PRESENT: state_d = CAPTURE;
         CAPTURE: state_d = EMIT;
         FINISH:  state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      trace_valid = (state_q == EMIT);
      busy        = (state_q != IDLE);
      done        = (state_q == FINISH);
   end

   // Datapath only moves on an accepted start or in CAPTURE; everything else holds.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= '0;
         iter_q     <= '0;
         num_iter_q <= '0;
         stop_q     <= 1'b0;
         fixed_q    <= 1'b0;
      end else if (state_q == IDLE && start) begin
         state_reg  <= init_state;
         iter_q     <= '0;
         num_iter_q <= num_iter;
         stop_q     <= stop_on_fixed;
         fixed_q    <= 1'b0;
      end else if (state_q == CAPTURE) begin
         fixed_q    <= (net_next_state == state_reg);
         state_reg  <= net_next_state;
         iter_q     <= iter_q + 1'b1;
      end
   end

   assign net_current_state    = state_reg;
   assign net_iteration_number = iter_q;
   assign trace_data           = state_reg;
   assign trace_iter           = iter_q;
   assign iter_count           = iter_q;
   assign fixed_point          = fixed_q;

endmodule

// File: tb/tb_network_sim_sequencer.sv
// Bench for network_sim_sequencer with a behavioural stub network and a sequence-level reference model.
module tb_network_sim_sequencer;
   import network_sim_pkg::*;

   localparam int unsigned SW = NET_STATE_W;
   localparam int unsigned IW = NET_ITER_W;

   logic          clk = 1'b0;
   logic          rst;
   logic          start;
   logic [SW-1:0] init_state;
   logic [IW-1:0] num_iter;
   logic          stop_on_fixed;
   logic [SW-1:0] net_current_state;
   logic [IW-1:0] net_iteration_number;
   logic [SW-1:0] net_next_state;
   logic          trace_valid;
   logic          trace_ready;
   logic [SW-1:0] trace_data;
   logic [IW-1:0] trace_iter;
   logic          busy;
   logic          done;
   logic          fixed_point;
   logic [IW-1:0] iter_count;

   int checks = 0;
   int errors = 0;
   int mode   = 0;

   network_sim_sequencer #(.STATE_W(SW), .ITER_W(IW)) dut (
      .clk                  (clk),
      .rst                  (rst),
      .start                (start),
      .init_state           (init_state),
      .num_iter             (num_iter),
      .stop_on_fixed        (stop_on_fixed),
      .net_current_state    (net_current_state),
      .net_iteration_number (net_iteration_number),
      .net_next_state       (net_next_state),
      .trace_valid          (trace_valid),
      .trace_ready          (trace_ready),
      .trace_data           (trace_data),
      .trace_iter           (trace_iter),
      .busy                 (busy),
      .done                 (done),
      .fixed_point          (fixed_point),
      .iter_count           (iter_count)
   );

   always #5 clk = ~clk;

   // Stub network: 0 identity, 1 increment, 2 smear-right (settles), 3 rotate-xor.
   function automatic logic [SW-1:0] net_f(input int m, input logic [SW-1:0] x);
      logic [SW-1:0] one;
      one = 1;
      case (m)
         0:       return x;
         1:       return x + one;
         2:       return x | (x >> 1);
         default: return {x[SW-2:0], x[SW-1]} ^ one;
      endcase
   endfunction

   always @(posedge clk) net_next_state <= net_f(mode, net_current_state);

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // rmode: 0 ready high, 1 random ready, 2 five-cycle stall on the iter-2 word.
   // abort_iter >= 0 asserts rst during PRESENT right after that word is accepted.
   task automatic run(input logic [SW-1:0] init, input int n, input bit stop,
                      input int rmode, input int abort_iter, input bit noise);
      logic [SW-1:0] exp_d[$];
      int            exp_i[$];
      logic [SW-1:0] s, p, held_d, wd;
      logic [IW-1:0] held_i;
      int            wi, words, last_i;
      bit            fx, finished, held, abort_next;
      int            stalls, cyc, stall_left;

      s = init; fx = 1'b0;
      exp_d.push_back(s); exp_i.push_back(0);
      for (int k = 1; k <= n; k++) begin
         p = s;
         s = net_f(mode, s);
         fx = (s == p);
         exp_d.push_back(s); exp_i.push_back(k);
         if (stop && fx) break;
      end
      words = exp_d.size();
      last_i = exp_i[words-1];

      finished = 0; held = 0; abort_next = 0; stalls = 0; cyc = 0; stall_left = 5;
      held_d = '0; held_i = '0;

      @(negedge clk);
      init_state = init; num_iter = IW'(n); stop_on_fixed = stop; start = 1'b1; trace_ready = 1'b1;
      @(negedge clk);
      start = 1'b0;

      while (!finished && cyc < 3000) begin
         cyc++;
         if (abort_next) begin
            rst = 1'b1;
            #1;
            check("abort_busy", 64'(busy), 64'(0));
            check("abort_valid", 64'(trace_valid), 64'(0));
            check("abort_fixed", 64'(fixed_point), 64'(0));
            check("abort_iter", 64'(iter_count), 64'(0));
            @(negedge clk);
            rst = 1'b0;
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               check("abort_no_done", 64'({done, busy}), 64'(0));
            end
            finished = 1;
         end else begin
            case (rmode)
               0: trace_ready = 1'b1;
               1: trace_ready = ($urandom_range(0, 3) != 0);
               default: begin
                  if (trace_valid && trace_iter == 2 && stall_left > 0) begin
                     trace_ready = 1'b0;
                     stall_left--;
                  end else begin
                     trace_ready = 1'b1;
                  end
               end
            endcase
            start = (noise && busy && !done) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (held) begin
               check("stall_valid", 64'(trace_valid), 64'(1));
               check("stall_data", 64'(trace_data), 64'(held_d));
               check("stall_iter", 64'(trace_iter), 64'(held_i));
               held = 0;
            end
            if (trace_valid) begin
               if (trace_ready) begin
                  if (exp_d.size() == 0) begin
                     check("extra_word", 64'(trace_iter), 64'(IW'(-1)));
                  end else begin
                     wd = exp_d.pop_front();
                     wi = exp_i.pop_front();
                     check("trace_data", 64'(trace_data), 64'(wd));
                     check("trace_iter", 64'(trace_iter), 64'(wi));
                     if (wi == abort_iter) abort_next = 1;
                  end
               end else begin
                  stalls++;
                  held = 1; held_d = trace_data; held_i = trace_iter;
               end
            end
            if (done) begin
               finished = 1;
               start = 1'b0;
               check("done_cycle", 64'(cyc), 64'(3 * (words - 1) + 2 + stalls));
               check("words_left", 64'(exp_d.size()), 64'(0));
               check("iter_count", 64'(iter_count), 64'(last_i));
               check("net_iter", 64'(net_iteration_number), 64'(last_i));
               check("fixed_point", 64'(fixed_point), 64'(fx));
            end else begin
               @(negedge clk);
            end
         end
      end
      start = 1'b0;
      check("run_finished", 64'(finished), 64'(1));
   endtask

   initial begin
      logic [SW-1:0] r;
      rst = 1'b1; start = 1'b0; init_state = '0; num_iter = '0; stop_on_fixed = 1'b0; trace_ready = 1'b0;
      @(negedge clk);
      check("rst_busy", 64'(busy), 64'(0));
      check("rst_valid", 64'(trace_valid), 64'(0));
      check("rst_done", 64'(done), 64'(0));
      check("rst_fixed", 64'(fixed_point), 64'(0));
      check("rst_iter", 64'(iter_count), 64'(0));
      check("rst_state", 64'(net_current_state), 64'(0));
      rst = 1'b0;
      @(negedge clk);

      mode = 0; run(SW'(5), 4, 1'b0, 0, -1, 1'b0);
      mode = 0; run(SW'(5), 10, 1'b1, 0, -1, 1'b0);
      mode = 1; run(SW'(0), 3, 1'b0, 2, -1, 1'b0);
      mode = 1; run(SW'(12'hABC), 0, 1'b0, 0, -1, 1'b0);
      mode = 3; run(SW'(7), 6, 1'b0, 0, 2, 1'b0);
      mode = 3; run(SW'(7), 3, 1'b0, 0, -1, 1'b0);

      for (int t = 0; t < 8; t++) begin
         mode = int'($urandom_range(0, 3));
         r = {$urandom, $urandom};
         if (mode == 2) r = r >> $urandom_range(30, 58);
         run(r, int'($urandom_range(0, 12)), 1'($urandom_range(0, 1)), 1, -1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
